// File: rtl/execute_cycle.sv
// RV64 execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// Define EXEC_MUL_EN to add a 64-iteration shift-add multiplier that holds upstream via BusyE.
module execute_cycle #(
  parameter int XLEN    = 64,
  parameter int MUL_CYC = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            MulE,
  input  logic [2:0]      ALUControlE,
  input  logic [1:0]      ForwardA_E,
  input  logic [1:0]      ForwardB_E,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] Imm_Ext_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [4:0]      RD_E,
  input  logic            FlushE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            BusyE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] ex_result;

  // Forward code 11 is unused and falls back to the register file value.
  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = ALU_ResultM;
      default: write_data = RD2_E;
    endcase
    src_b = ALUSrcE ? Imm_Ext_E : write_data;
  end

  always_comb begin
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110:  alu_result = src_a << src_b[5:0];
      default: alu_result = src_a >> src_b[5:0];
    endcase
  end

  assign PCSrcE    = BranchE & (alu_result == '0);
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EXEC_MUL_EN
  localparam int CW = $clog2(MUL_CYC);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;

  // The IDLE term stalls upstream in the same cycle the mul is first seen.
  assign BusyE     = ((state == IDLE) && MulE && !FlushE) || (state == RUN);
  assign ex_result = (state == DONE) ? acc : alu_result;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (MulE && !FlushE) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (FlushE) begin
            state <= IDLE;
          end else begin
            if (mcand[0]) acc <= acc + mplier;
            mplier <= mplier << 1;
            mcand  <= mcand >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(MUL_CYC - 1)) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic mul_unused;

  assign mul_unused = MulE;
  assign BusyE      = 1'b0;
  assign ex_result  = alu_result;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else if (FlushE || BusyE) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      WriteDataM  <= '0;
      ALU_ResultM <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      WriteDataM  <= write_data;
      ALU_ResultM <= ex_result;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized and directed bench for execute_cycle against a behavioural model.
// Multiplier scenarios are built only when EXEC_MUL_EN is defined.
module tb_execute_cycle;
  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, FlushE;
  logic [2:0]  ALUControlE;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [63:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [4:0]  RD_E;
  logic        PCSrcE, BusyE, RegWriteM, MemWriteM, ResultSrcM;
  logic [63:0] PCTargetE, PCPlus4M, WriteDataM, ALU_ResultM;
  logic [4:0]  RD_M;

  int checks = 0;
  int errors = 0;

  // Model state: predicted EX/MEM contents.
  logic        e_rw, e_mw, e_rs;
  logic [4:0]  e_rd;
  logic [63:0] e_pc4, e_wd, e_alu;

  wire [199:0] m_bus = {RegWriteM, MemWriteM, ResultSrcM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM};

  execute_cycle #(.XLEN(64), .MUL_CYC(64)) dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MulE(MulE),
    .ALUControlE(ALUControlE), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .ResultW(ResultW), .RD_E(RD_E), .FlushE(FlushE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .BusyE(BusyE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [63:0] ref_alu(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int sh;
    sh = int'(b[5:0]);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd6: return a * (64'd1 << sh);
      default: return a / (64'd1 << sh);
    endcase
  endfunction

  function automatic logic [63:0] ref_fwd(input logic [1:0] c, input logic [63:0] rd, input logic [63:0] w,
                                          input logic [63:0] m);
    return (c == 2'b01) ? w : (c == 2'b10) ? m : rd;
  endfunction

  function automatic logic [63:0] cur_a();
    return ref_fwd(ForwardA_E, RD1_E, ResultW, e_alu);
  endfunction

  function automatic logic [63:0] cur_b();
    return ALUSrcE ? Imm_Ext_E : ref_fwd(ForwardB_E, RD2_E, ResultW, e_alu);
  endfunction

  function automatic logic [199:0] exp_bus();
    return {e_rw, e_mw, e_rs, e_rd, e_pc4, e_wd, e_alu};
  endfunction

  task automatic model_bubble();
    {e_rw, e_mw, e_rs, e_rd, e_pc4, e_wd, e_alu} = '0;
  endtask

  task automatic model_edge();
    logic [63:0] r, wd;
    r  = ref_alu(ALUControlE, cur_a(), cur_b());
    wd = ref_fwd(ForwardB_E, RD2_E, ResultW, e_alu);
    if (FlushE) model_bubble();
    else begin
      {e_rw, e_mw, e_rs, e_rd, e_pc4} = {RegWriteE, MemWriteE, ResultSrcE, RD_E, PCPlus4E};
      e_wd  = wd;
      e_alu = r;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_quiet();
    {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, MulE, FlushE} = '0;
    ALUControlE = 3'd0;
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    {RD1_E, RD2_E, Imm_Ext_E, ResultW} = '0;
    PCE = 64'h1000;
    PCPlus4E = 64'h1004;
    RD_E = 5'd1;
  endtask

  task automatic rand_inputs();
    {RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE} = 5'($urandom);
    ALUControlE = 3'($urandom);
    ForwardA_E  = 2'($urandom);
    ForwardB_E  = 2'($urandom);
    RD1_E = {$urandom, $urandom};
    RD2_E = {$urandom, $urandom};
    Imm_Ext_E = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 80)) : {$urandom, $urandom};
    PCE = {$urandom, $urandom};
    PCPlus4E = PCE + 64'd4;
    ResultW = {$urandom, $urandom};
    RD_E = 5'($urandom);
    FlushE = ($urandom_range(0, 7) == 0);
`ifdef EXEC_MUL_EN
    MulE = 1'b0;
`else
    MulE = 1'($urandom);
`endif
    if ($urandom_range(0, 3) == 0) begin
      RD2_E = RD1_E;
      ForwardA_E = 2'b00;
      ForwardB_E = 2'b00;
      ALUSrcE = 1'b0;
      ALUControlE = 3'd1;
    end
  endtask

  task automatic test_reset();
    set_quiet();
    rand_inputs();
    FlushE = 1'b0;
    MulE = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (m_bus !== '0) begin errors++; $display("FAIL reset_m got=%h exp=0", m_bus); end
    checks++;
    if (BusyE !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", BusyE); end
    checks++;
    if (PCTargetE !== PCE + Imm_Ext_E)
      begin errors++; $display("FAIL reset_target got=%h exp=%h", PCTargetE, PCE + Imm_Ext_E); end
    rst = 1'b1;
    model_bubble();
  endtask

  task automatic test_alu_forward();
    set_quiet();
    RD1_E = 64'd5; ResultW = 64'd7; ForwardA_E = 2'b01; Imm_Ext_E = 64'd3; ALUSrcE = 1'b1;
    RegWriteE = 1'b1;
    model_edge();
    tick();
    checks++;
    if (ALU_ResultM !== 64'd10) begin errors++; $display("FAIL fwd_add got=%0d exp=10", ALU_ResultM); end
    set_quiet();
    RD1_E = 64'd9; RD2_E = 64'd9; ALUControlE = 3'd1; BranchE = 1'b1;
    PCE = 64'h2000; Imm_Ext_E = 64'h40;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL beq_taken got=%b exp=1", PCSrcE); end
    checks++;
    if (PCTargetE !== 64'h2040) begin errors++; $display("FAIL beq_target got=%h exp=2040", PCTargetE); end
    model_edge();
    tick();
  endtask

  task automatic test_back_to_back();
    set_quiet();
    RD1_E = 64'h0c; Imm_Ext_E = 64'd4; ALUSrcE = 1'b1; RegWriteE = 1'b1;
    model_edge();
    tick();
    checks++;
    if (ALU_ResultM !== 64'h10) begin errors++; $display("FAIL b2b_add got=%h exp=10", ALU_ResultM); end
    RD1_E = 64'hdead; ForwardA_E = 2'b10; ALUControlE = 3'd6;
    model_edge();
    tick();
    checks++;
    if (ALU_ResultM !== 64'h100) begin errors++; $display("FAIL b2b_sll got=%h exp=100", ALU_ResultM); end
  endtask

  task automatic test_flush();
    set_quiet();
    RegWriteE = 1'b1; MemWriteE = 1'b1; RD1_E = 64'd4; RD2_E = 64'd4; ALUControlE = 3'd1;
    BranchE = 1'b1; FlushE = 1'b1;
    #1;
    checks++;
    if (PCSrcE !== 1'b1) begin errors++; $display("FAIL flush_pcsrc got=%b exp=1", PCSrcE); end
    model_edge();
    tick();
    checks++;
    if ({RegWriteM, MemWriteM, ALU_ResultM} !== 66'd0)
      begin errors++; $display("FAIL flush_bubble got=%b%b %h exp=0", RegWriteM, MemWriteM, ALU_ResultM); end
  endtask

  task automatic test_random();
    logic exp_src;
    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      #1;
      exp_src = BranchE && (ref_alu(ALUControlE, cur_a(), cur_b()) == 64'd0);
      checks++;
      if (PCSrcE !== exp_src) begin errors++; $display("FAIL rnd_pcsrc i=%0d got=%b exp=%b", i, PCSrcE, exp_src); end
      checks++;
      if (BusyE !== 1'b0) begin errors++; $display("FAIL rnd_busy i=%0d got=%b exp=0", i, BusyE); end
      model_edge();
      tick();
      checks++;
      if (m_bus !== exp_bus()) begin errors++; $display("FAIL rnd_m i=%0d got=%h exp=%h", i, m_bus, exp_bus()); end
    end
  endtask

  task automatic test_reset_midstream();
    set_quiet();
    RD1_E = 64'h55; Imm_Ext_E = 64'd1; ALUSrcE = 1'b1; RegWriteE = 1'b1;
    model_edge();
    tick();
    checks++;
    if (ALU_ResultM !== 64'h56) begin errors++; $display("FAIL pre_reset got=%h exp=56", ALU_ResultM); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (m_bus !== '0) begin errors++; $display("FAIL async_reset got=%h exp=0", m_bus); end
    rst = 1'b1;
    model_bubble();
    RD1_E = 64'h70; Imm_Ext_E = 64'h07; RD_E = 5'd9;
    model_edge();
    tick();
    checks++;
    if (m_bus !== exp_bus()) begin errors++; $display("FAIL post_reset got=%h exp=%h", m_bus, exp_bus()); end
  endtask

`ifdef EXEC_MUL_EN
  task automatic test_mul(input logic [63:0] a, input logic [63:0] b, input logic [1:0] fa);
    logic [63:0] prod;
    int busy;
    rand_inputs();
    FlushE = 1'b0; MulE = 1'b1; RegWriteE = 1'b1; BranchE = 1'b0; ALUSrcE = 1'b1;
    ForwardA_E = fa; Imm_Ext_E = b;
    if (fa == 2'b01) ResultW = a; else RD1_E = a;
    prod = cur_a() * b;
    #1;
    busy = 0;
    for (int n = 0; n < 100 && BusyE === 1'b1; n++) begin
      busy++;
      model_bubble();
      tick();
      checks++;
      if (RegWriteM !== 1'b0) begin errors++; $display("FAIL mul_regw n=%0d got=%b exp=0", n, RegWriteM); end
      ResultW = {$urandom, $urandom};
    end
    checks++;
    if (busy !== 65) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=65", busy); end
    model_edge();
    e_alu = prod;
    tick();
    checks++;
    if (m_bus !== exp_bus()) begin errors++; $display("FAIL mul_result got=%h exp=%h", m_bus, exp_bus()); end
    set_quiet();
    #1;
    checks++;
    if (BusyE !== 1'b0) begin errors++; $display("FAIL mul_norestart got=%b exp=0", BusyE); end
  endtask

  task automatic test_mul_abort();
    rand_inputs();
    FlushE = 1'b0; MulE = 1'b1;
    model_bubble();
    tick();
    for (int n = 0; n < 10; n++) begin model_bubble(); tick(); end
    checks++;
    if (BusyE !== 1'b1) begin errors++; $display("FAIL abort_running got=%b exp=1", BusyE); end
    FlushE = 1'b1;
    model_edge();
    tick();
    set_quiet();
    RD1_E = 64'd20; Imm_Ext_E = 64'd22; ALUSrcE = 1'b1; RegWriteE = 1'b1;
    #1;
    checks++;
    if (BusyE !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", BusyE); end
    checks++;
    if (m_bus !== '0) begin errors++; $display("FAIL abort_bubble got=%h exp=0", m_bus); end
    model_edge();
    tick();
    checks++;
    if (ALU_ResultM !== 64'd42) begin errors++; $display("FAIL abort_add got=%0d exp=42", ALU_ResultM); end
  endtask
`else
  task automatic test_mul_ignored();
    set_quiet();
    MulE = 1'b1; RD1_E = 64'd100; Imm_Ext_E = 64'd23; ALUSrcE = 1'b1; RegWriteE = 1'b1;
    #1;
    checks++;
    if (BusyE !== 1'b0) begin errors++; $display("FAIL nomul_busy got=%b exp=0", BusyE); end
    model_edge();
    tick();
    checks++;
    if (ALU_ResultM !== 64'd123) begin errors++; $display("FAIL nomul_add got=%0d exp=123", ALU_ResultM); end
  endtask
`endif

  initial begin
    test_reset();
    test_alu_forward();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_midstream();
`ifdef EXEC_MUL_EN
    test_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b00);
    test_mul({$urandom, $urandom}, {$urandom, $urandom}, 2'b01);
    test_mul({$urandom, $urandom}, 64'($urandom), 2'b10);
    test_mul_abort();
`else
    test_mul_ignored();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
